board_cell_renderer: RTL



---
 rtl/battleship_pkg.sv | 28 ++
 rtl/board_cell_renderer_if.sv | 27 ++
 rtl/axis_cell_tracker.sv | 47 ++++
 rtl/board_cell_renderer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared cell codes and 24-bit colours for the battleship board renderer.
package battleship_pkg;

  typedef enum logic [1:0] {
    WATER = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_state_t;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_WATER  = 24'h0040A0;
  localparam logic [23:0] COL_SHIP   = 24'hE59C14;
  localparam logic [23:0] COL_HIT    = 24'hFF0000;
  localparam logic [23:0] COL_MISS   = 24'h808080;
  localparam logic [23:0] COL_GRID   = 24'hFFFFFF;
  localparam logic [23:0] COL_CURSOR = 24'hFFE000;

  function automatic logic [23:0] cell_colour(input cell_state_t state);
    case (state)
      SHIP:    return COL_SHIP;
      HIT:     return COL_HIT;
      MISS:    return COL_MISS;
      default: return COL_WATER;
    endcase
  endfunction

endpackage

// File: rtl/board_cell_renderer_if.sv
// Pixel stream, board contents and cursor in; rendered colour out.
interface board_cell_renderer_if #(
  parameter int GRID_COLS = 5,
  parameter int GRID_ROWS = 5
);
  logic                             pix_en;
  logic [9:0]                       counterX;
  logic [9:0]                       counterY;
  logic [2*GRID_COLS*GRID_ROWS-1:0] board_state;
  logic [$clog2(GRID_COLS)-1:0]     cursor_col;
  logic [$clog2(GRID_ROWS)-1:0]     cursor_row;
  logic                             cursor_en;
  logic [7:0]                       R;
  logic [7:0]                       G;
  logic [7:0]                       B;
  logic                             in_board;

  modport master (
    output pix_en, counterX, counterY, board_state, cursor_col, cursor_row, cursor_en,
    input  R, G, B, in_board
  );

  modport slave (
    input  pix_en, counterX, counterY, board_state, cursor_col, cursor_row, cursor_en,
    output R, G, B, in_board
  );
endinterface

// File: rtl/axis_cell_tracker.sv
// Incremental cell index / in-cell offset along one axis; resyncs whenever
// the coordinate equals ORIGIN, so no divider is needed.
module axis_cell_tracker #(
  parameter int N_CELLS   = 5,
  parameter int CELL_SIZE = 44,
  parameter int ORIGIN    = 66,
  localparam int IW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1,
  localparam int OW = $clog2(CELL_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic [9:0]    coord,
  input  logic          sync,
  output logic [IW-1:0] idx,
  output logic [OW-1:0] off,
  output logic          active
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      off    <= '0;
      active <= 1'b0;
    end else if (step) begin
      if (sync && coord == 10'(ORIGIN)) begin
        idx    <= '0;
        off    <= '0;
        active <= 1'b1;
      end else if (active) begin
        if (off == OW'(CELL_SIZE - 1)) begin
          off <= '0;
          // Leaving the last cell ends the board span for this axis.
          if (idx == IW'(N_CELLS - 1)) begin
            idx    <= '0;
            active <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          off <= off + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_cell_renderer.sv
// Renders a frame-shadowed battleship board with grid and blinking cursor ring;
// two registered stages give a fixed 2-strobe latency.
module board_cell_renderer
  import battleship_pkg::*;
#(
  parameter int GRID_COLS    = 5,
  parameter int GRID_ROWS    = 5,
  parameter int CELL_SIZE    = 44,
  parameter int ORIGIN_X     = 66,
  parameter int ORIGIN_Y     = 128,
  parameter int LINE_W       = 2,
  parameter int MARGIN       = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  board_cell_renderer_if.slave   bus
);

  localparam int XIW = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int YIW = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int OW  = $clog2(CELL_SIZE);
  localparam int CW  = $clog2(GRID_COLS);
  localparam int RW  = $clog2(GRID_ROWS);
  localparam int BW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int NB  = 2 * GRID_COLS * GRID_ROWS;

  localparam logic [10:0]   X_LO    = 11'(ORIGIN_X);
  localparam logic [10:0]   X_HI    = 11'(ORIGIN_X + GRID_COLS * CELL_SIZE);
  localparam logic [10:0]   Y_LO    = 11'(ORIGIN_Y);
  localparam logic [10:0]   Y_HI    = 11'(ORIGIN_Y + GRID_ROWS * CELL_SIZE);
  localparam logic [OW-1:0] LINE_LIM = OW'(LINE_W);
  localparam logic [OW-1:0] RING_LO  = OW'(MARGIN);
  localparam logic [OW-1:0] RING_HI  = OW'(CELL_SIZE - 1 - MARGIN);

  logic [XIW-1:0] col_idx;
  logic [YIW-1:0] row_idx;
  logic [OW-1:0]  offx;
  logic [OW-1:0]  offy;
  logic           in_x;
  logic           in_y;
  logic           step_y;
  logic           frame_start;

  logic           board_flag_reg;
  logic [NB-1:0]  shadow_board_reg;
  logic [CW-1:0]  shadow_ccol_reg;
  logic [RW-1:0]  shadow_crow_reg;
  logic           shadow_cen_reg;
  logic [BW-1:0]  blink_cnt_reg;
  logic           phase_visible_reg;
  logic [23:0]    rgb_reg;
  logic           in_board_reg;

  logic           in_board_next;
  logic [23:0]    colour_next;
  cell_state_t    cell_code;
  logic           on_ring;
  logic           cursor_hit;

  assign step_y      = bus.pix_en && (bus.counterX == 10'd0);
  assign frame_start = (bus.counterX == 10'd0) && (bus.counterY == 10'd0);

  axis_cell_tracker #(.N_CELLS(GRID_COLS), .CELL_SIZE(CELL_SIZE), .ORIGIN(ORIGIN_X)) u_track_x (
    .clk(clk), .rst_n(rst_n), .step(bus.pix_en), .coord(bus.counterX), .sync(1'b1),
    .idx(col_idx), .off(offx), .active(in_x)
  );

  axis_cell_tracker #(.N_CELLS(GRID_ROWS), .CELL_SIZE(CELL_SIZE), .ORIGIN(ORIGIN_Y)) u_track_y (
    .clk(clk), .rst_n(rst_n), .step(step_y), .coord(bus.counterY), .sync(1'b1),
    .idx(row_idx), .off(offy), .active(in_y)
  );

  // Counter range flag masks stale tracker state after a jump in the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_flag_reg <= 1'b0;
    end else if (bus.pix_en) begin
      board_flag_reg <= ({1'b0, bus.counterX} >= X_LO) && ({1'b0, bus.counterX} < X_HI) &&
                        ({1'b0, bus.counterY} >= Y_LO) && ({1'b0, bus.counterY} < Y_HI);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_board_reg  <= '0;
      shadow_ccol_reg   <= '0;
      shadow_crow_reg   <= '0;
      shadow_cen_reg    <= 1'b0;
      blink_cnt_reg     <= '0;
      phase_visible_reg <= 1'b1;
    end else if (bus.pix_en && frame_start) begin
      shadow_board_reg <= bus.board_state;
      shadow_ccol_reg  <= bus.cursor_col;
      shadow_crow_reg  <= bus.cursor_row;
      shadow_cen_reg   <= bus.cursor_en;
      if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg     <= '0;
        phase_visible_reg <= ~phase_visible_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    in_board_next = in_x && in_y && board_flag_reg;
    cell_code     = cell_state_t'(shadow_board_reg[2*(int'(row_idx)*GRID_COLS + int'(col_idx)) +: 2]);
    on_ring       = (offx < RING_LO) || (offy < RING_LO) || (offx > RING_HI) || (offy > RING_HI);
    // Out-of-range cursor indices simply never equal a tracker index.
    cursor_hit    = shadow_cen_reg && phase_visible_reg &&
                    (int'(shadow_ccol_reg) == int'(col_idx)) &&
                    (int'(shadow_crow_reg) == int'(row_idx));
    colour_next   = COL_BLACK;
    if (in_board_next) begin
      if (offx < LINE_LIM || offy < LINE_LIM) begin
        colour_next = COL_GRID;
      end else if (on_ring) begin
        colour_next = cursor_hit ? COL_CURSOR : COL_WATER;
      end else begin
        colour_next = cell_colour(cell_code);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_reg      <= COL_BLACK;
      in_board_reg <= 1'b0;
    end else if (bus.pix_en) begin
      rgb_reg      <= colour_next;
      in_board_reg <= in_board_next;
    end
  end

  assign bus.R        = rgb_reg[23:16];
  assign bus.G        = rgb_reg[15:8];
  assign bus.B        = rgb_reg[7:0];
  assign bus.in_board = in_board_reg;

endmodule
